// File: rtl/square_22bit_seq.sv
// Sequential shift-and-add squarer: one partial product per cycle, 12-cycle start-to-done.
// Optional SQUARE_CHECK_EN adds rad_in/residue/root_ok to judge root_in as floor sqrt of rad_in.
module square_22bit_seq #(
  parameter int W_ROOT = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W_ROOT-1:0]     root_in,
`ifdef SQUARE_CHECK_EN
  input  logic [2*W_ROOT-1:0]   rad_in,
  output logic [2*W_ROOT:0]     residue,
  output logic                  root_ok,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [2*W_ROOT-1:0]   sq_out
);

  localparam int WR = 2 * W_ROOT;
  localparam int CW = $clog2(W_ROOT);
  localparam logic [CW-1:0] LAST = CW'(W_ROOT - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_reg, state_next;
  logic              load, step, finish;
  logic [W_ROOT-1:0] operand_reg, mult_reg;
  logic [WR-1:0]     acc_reg;
  logic [CW-1:0]     count_reg;
  logic [WR-1:0]     addend, acc_sum;
  logic [WR-1:0]     carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (count_reg == LAST) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign finish = step && (count_reg == LAST);

  // Partial product for the current multiplier bit, aligned by the bit index.
  assign addend = mult_reg[count_reg] ? ({{W_ROOT{1'b0}}, operand_reg} << count_reg) : '0;

  assign carry[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < WR; gi++) begin : g_ripple
      assign acc_sum[gi] = acc_reg[gi] ^ addend[gi] ^ carry[gi];
      if (gi < WR - 1) begin : g_carry
        assign carry[gi+1] = (acc_reg[gi] & addend[gi]) | (carry[gi] & (acc_reg[gi] ^ addend[gi]));
      end
    end
  endgenerate

`ifdef SQUARE_CHECK_EN
  logic [WR-1:0] rad_reg;
  logic [WR:0]   diff, twice_root;

  assign diff       = {1'b0, rad_reg} - {1'b0, acc_sum};
  assign twice_root = {{(WR - W_ROOT){1'b0}}, operand_reg, 1'b0};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_reg <= '0;
      mult_reg    <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      sq_out      <= '0;
`ifdef SQUARE_CHECK_EN
      rad_reg     <= '0;
      residue     <= '0;
      root_ok     <= 1'b0;
`endif
    end else if (load) begin
      operand_reg <= root_in;
      mult_reg    <= root_in;
      acc_reg     <= '0;
      count_reg   <= '0;
`ifdef SQUARE_CHECK_EN
      rad_reg     <= rad_in;
`endif
    end else if (step) begin
      acc_reg   <= acc_sum;
      count_reg <= count_reg + CW'(1);
      if (finish) begin
        sq_out <= acc_sum;
`ifdef SQUARE_CHECK_EN
        residue <= diff;
        // Non-negative residue no larger than 2*root means root is the floor sqrt.
        root_ok <= !diff[WR] && (diff <= twice_root);
`endif
      end
    end
  end

endmodule

// File: tb/tb_square_22bit_seq.sv
// Self-checking bench for square_22bit_seq: directed corners, random operands,
// continuous-start streaming and mid-operation reset, checked against plain arithmetic.
module tb_square_22bit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] root_in;
  logic        busy;
  logic        done;
  logic [21:0] sq_out;
`ifdef SQUARE_CHECK_EN
  logic [21:0] rad_in;
  logic [22:0] residue;
  logic        root_ok;
`endif

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [21:0] prev_sq  = '0;

  always #5 clk = ~clk;

  square_22bit_seq #(.W_ROOT(11)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .root_in (root_in),
`ifdef SQUARE_CHECK_EN
    .rad_in  (rad_in),
    .residue (residue),
    .root_ok (root_ok),
`endif
    .busy    (busy),
    .done    (done),
    .sq_out  (sq_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation from an idle DUT; inputs are scrambled after the start edge.
  task automatic do_square(input logic [10:0] r, input logic [21:0] rad);
    int exp_sq;
    exp_sq = int'(r) * int'(r);
    @(negedge clk);
    start   = 1'b1;
    root_in = r;
`ifdef SQUARE_CHECK_EN
    rad_in  = rad;
`endif
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(k <= 12));
      check("done", 32'(done), 32'(k == 12));
      if (k < 12) check("sq_hold", 32'(sq_out), 32'(prev_sq));
      else        check("sq_out", 32'(sq_out), 32'(exp_sq));
`ifdef SQUARE_CHECK_EN
      if (k == 12) begin
        int e;
        logic [22:0] exp_res;
        e       = int'(rad) - exp_sq;
        exp_res = 23'(e);
        check("residue", 32'(residue), 32'(exp_res));
        check("root_ok", 32'(root_ok), 32'(e >= 0 && e <= 2 * int'(r)));
      end
      rad_in = 22'($urandom);
`endif
      root_in = 11'($urandom);
      start   = (k <= 12) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    prev_sq = 22'(exp_sq);
    $display("square root_in=%0d rad_in=%0d sq_out=%0d", r, rad, sq_out);
  endtask

  initial begin
    logic [10:0] vals [52];
    logic [10:0] r;
    logic [21:0] rad;
    int          n_done;

    rst_n   = 1'b0;
    start   = 1'b0;
    root_in = '0;
`ifdef SQUARE_CHECK_EN
    rad_in  = '0;
`endif
    #12;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sq", 32'(sq_out), 32'(0));
`ifdef SQUARE_CHECK_EN
    check("rst_residue", 32'(residue), 32'(0));
    check("rst_root_ok", 32'(root_ok), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    do_square(11'd0, 22'd0);
    do_square(11'd2047, 22'd4190209);
    do_square(11'd11, 22'd100);
    do_square(11'd1234, 22'd1522756);
    do_square(11'd10, 22'd120);
    for (int i = 0; i < 8; i++) begin
      r = 11'($urandom);
      if (i % 2 == 1) rad = 22'(int'(r) * int'(r) + int'($urandom_range(0, 2 * int'(r))));
      else            rad = 22'($urandom);
      do_square(r, rad);
    end

    // Start held high, root_in changing every cycle: only IDLE-sampled values count.
    for (int j = 0; j < 52; j++) vals[j] = 11'($urandom);
    n_done = 0;
    for (int j = 0; j < 52; j++) begin
      start   = 1'b1;
      root_in = vals[j];
      @(negedge clk);
      n_done += int'(done);
      check("stream_busy", 32'(busy), 32'(j % 13 != 12));
      check("stream_done", 32'(done), 32'(j % 13 == 11));
      if (j % 13 == 11)
        check("stream_sq", 32'(sq_out), 32'(int'(vals[j-11]) * int'(vals[j-11])));
    end
    start = 1'b0;
    check("stream_done_count", 32'(n_done), 32'(4));
    $display("stream dones=%0d last sq_out=%0d", n_done, sq_out);

    // Asynchronous reset in the middle of CALC aborts without a done pulse.
    start   = 1'b1;
    root_in = 11'd500;
    @(posedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_sq", 32'(sq_out), 32'(0));
`ifdef SQUARE_CHECK_EN
    check("abort_residue", 32'(residue), 32'(0));
    check("abort_root_ok", 32'(root_ok), 32'(0));
`endif
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      n_done += int'(done);
    end
    check("abort_no_done", 32'(n_done), 32'(0));
    $display("abort sq_out=%0d busy=%0d", sq_out, busy);
    prev_sq = '0;
    do_square(11'd3, 22'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/square_22bit_seq.md
SQUARE_22BIT_SEQ -- requirements
Module: square_22bit_seq

Interface
REQ-001 SHALL declare parameter W_ROOT, default 11, root operand width; result width is 2*W_ROOT (22).
REQ-002 SHALL declare port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL declare port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL declare port start, input, 1, request to square root_in; sampled only in IDLE.
REQ-005 SHALL declare port root_in, input, 11, unsigned root operand; must be valid when start is sampled.
REQ-006 SHALL declare port busy, output, 1, high in CALC and DONE.
REQ-007 SHALL declare port done, output, 1, one-cycle pulse when sq_out is updated.
REQ-008 SHALL declare port sq_out, output, 22, unsigned root_in squared; holds until the next completion.

Function
REQ-009 SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-010 In IDLE with start=1 at edge N: latch root_in into operand and multiplier registers, clear the 22-bit accumulator, clear the 4-bit bit counter, go to CALC.
REQ-011 In IDLE with start=0: remain in IDLE; no register changes.
REQ-012 Each CALC edge: if the multiplier bit at the counter index is 1, accumulator += operand shifted left by the counter value (22-bit ripple add, carry-out discarded); counter increments.
REQ-013 CALC SHALL run exactly 11 edges (N+1..N+11); the edge processing counter value 10 moves to DONE and loads sq_out with the final accumulator value.
REQ-014 done SHALL be 1 for exactly the cycle after edge N+11; edge N+12 returns to IDLE.
REQ-015 Start-to-done latency SHALL be 12 cycles; next start is accepted at the earliest at edge N+13.
REQ-016 start SHALL be ignored in CALC and DONE, with no queuing; root_in changes after edge N SHALL NOT affect the result.
REQ-017 Accumulator SHALL never overflow: max result 2047^2 = 4190209 < 2^22.
REQ-018 root_in = 0 SHALL still take the full 12 cycles and yield sq_out = 0.

Reset
REQ-019 rst_n=0 SHALL immediately, without a clock, force IDLE, busy=0, done=0, sq_out=0, and accumulator, counter and operand registers to 0.
REQ-020 Reset during CALC or DONE SHALL abort the operation with no done pulse; after release, the first start SHALL behave as in REQ-010.

Configuration
REQ-021 Macro SQUARE_CHECK_EN SHALL, when defined, add ports rad_in (input, 22, radicand latched with root_in at start), residue (output, 23, two's complement rad_in - sq_out) and root_ok (output, 1).
REQ-022 With SQUARE_CHECK_EN: residue and root_ok SHALL update at the same edge as sq_out; root_ok = 1 iff 0 <= residue <= 2*root (root is the floor sqrt of rad_in); both reset to 0.
REQ-023 Without SQUARE_CHECK_EN: those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-024 Reset, start with root_in=0 -> done pulse 12 cycles later, sq_out=0, busy high for 12 cycles.
REQ-025 root_in=2047 -> sq_out=4190209 (0x3FF001); root_in=1234 -> sq_out=1522756; done exactly one cycle wide each time.
REQ-026 start held high continuously with root_in changing every cycle -> only the value sampled in IDLE is squared; one done per 13 cycles.
REQ-027 rst_n low at cycle 5 of CALC -> busy=0, sq_out=0, no done pulse; new start with root_in=3 -> sq_out=9.
REQ-028 SQUARE_CHECK_EN: rad_in=4190209, root_in=2047 -> residue=0, root_ok=1; rad_in=100, root_in=11 -> residue=-21, root_ok=0; rad_in=120, root_in=10 -> residue=20, root_ok=1.
